uart_tx_scheduler: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Baud select codes, scheduler states and owner-index width helper.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam logic [2:0] BAUD_230400 = 3'd5;
  localparam logic [2:0] BAUD_460800 = 3'd6;
  localparam logic [2:0] BAUD_921600 = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } uart_sched_state_t;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first asserted request after 'last', with wrap.
// Purely combinational; shared by arbiters in this codebase.
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  // scan from last+1 upward, wrapping, keep the first hit
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      logic [W-1:0] j;
      j = W'((int'(last) + i) % N);
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among requesters.
// Optional owner lock bursts enabled by defining UART_ARB_LOCK_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_BITS       = 1,
  parameter int START_TIMEOUT  = 8,
  parameter int LOCK_MAX_BYTES = 16
) (
  input  logic                      CLK,
  input  logic                      reset_external_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [8*N_REQ-1:0]        req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          req_lock,
`endif
  input  logic [2:0]                cfg_sel,
  input  logic                      baud_tick,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  output logic [owner_w(N_REQ)-1:0] tx_owner,
  output logic [N_REQ-1:0]          grant_ack,
  output logic [2:0]                baud_sel,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int OW = owner_w(N_REQ);
  localparam int CW = 16;
  localparam logic [CW-1:0] TO_LAST =
    CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam uart_sched_state_t DONE_NEXT =
    (GAP_BITS > 0) ? ST_GAP : ST_IDLE;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("N_REQ out of range 2..8");
  end
  if (LOCK_MAX_BYTES < 1) begin : g_bad_lock
    $error("LOCK_MAX_BYTES must be >= 1");
  end

  uart_sched_state_t state, next;
  logic [CW-1:0]     cnt;
  logic [OW-1:0]     last;
  logic [N_REQ-1:0]  pick_oh;
  logic [OW-1:0]     pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  win_oh;
  logic [OW-1:0]     win_idx;
  logic              lock_hit;
  logic              load_go;
  logic              timeout;
  logic [7:0]        bytes [N_REQ];

  uart_rr_pick #(
    .N(N_REQ),
    .W(OW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef UART_ARB_LOCK_EN
  localparam int BW = $clog2(LOCK_MAX_BYTES + 1);
  logic [BW-1:0] burst;

  assign lock_hit = req[last] && req_lock[last]
                 && (burst < BW'(LOCK_MAX_BYTES));

  // consecutive bytes granted to the current owner
  always_ff @(posedge CLK or negedge reset_external_n) begin
    if (!reset_external_n) begin
      burst <= '0;
    end else if (load_go) begin
      burst <= lock_hit ? burst + 1'b1 : BW'(1);
    end
  end
`else
  assign lock_hit = 1'b0;
`endif

  assign load_go = (state == ST_ARB) && pick_any;

  // unflatten request bytes and choose the winner
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bytes[i] = req_data[8*i +: 8];
    end
    win_idx = pick_idx;
    win_oh  = pick_oh;
    if (lock_hit) begin
      win_idx = last;
      win_oh  = '0;
      win_oh[last] = 1'b1;
    end
  end

  // next-state logic for the frame sequencer
  always_comb begin
    next    = state;
    timeout = 1'b0;
    unique case (state)
      ST_IDLE:
        if (|req) next = ST_ARB;
      ST_ARB:
        next = pick_any ? ST_LOAD : ST_IDLE;
      ST_LOAD:
        next = ST_WAIT_BUSY;
      ST_WAIT_BUSY:
        if (tx_busy) begin
          next = ST_WAIT_DONE;
        end else if (cnt == TO_LAST) begin
          next    = ST_IDLE;
          timeout = 1'b1;
        end
      ST_WAIT_DONE:
        if (!tx_busy) next = DONE_NEXT;
      ST_GAP:
        if (baud_tick && cnt == GAP_LAST)
          next = ST_IDLE;
      default:
        next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLK or negedge reset_external_n) begin
    if (!reset_external_n) state <= ST_IDLE;
    else                   state <= next;
  end

  // registered outputs, rr pointer and shared cycle/tick counter
  always_ff @(posedge CLK or negedge reset_external_n) begin
    if (!reset_external_n) begin
      cnt         <= '0;
      last        <= OW'(N_REQ - 1);
      tx_start    <= 1'b0;
      tx_data     <= '0;
      tx_owner    <= '0;
      grant_ack   <= '0;
      baud_sel    <= BAUD_9600;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_start    <= load_go;
      grant_ack   <= load_go ? win_oh : '0;
      err_timeout <= timeout;
      busy        <= (next != ST_IDLE);
      if (load_go) begin
        tx_owner <= win_idx;
        tx_data  <= bytes[win_idx];
      end
      if (state == ST_LOAD) last <= tx_owner;
      if (state == ST_IDLE) baud_sel <= cfg_sel;
      if (load_go || (state == ST_WAIT_DONE
                      && next == ST_GAP)) begin
        cnt <= '0;
      end else if (state == ST_LOAD
                   || state == ST_WAIT_BUSY
                   || (state == ST_GAP && baud_tick)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (default parameters).
// Checks arbitration, latency, gap, baud hold, timeout and reset.
module tb_uart_tx_scheduler;

  localparam int N = 4;

  logic          CLK = 1'b0;
  logic          reset_external_n;
  logic [N-1:0]  req;
  logic [8*N-1:0] req_data;
  logic [2:0]    cfg_sel;
  logic          baud_tick;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [1:0]    tx_owner;
  logic [N-1:0]  grant_ack;
  logic [2:0]    baud_sel;
  logic          busy;
  logic          err_timeout;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0]  req_lock = '0;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 CLK = ~CLK;

  uart_tx_scheduler dut (
`ifdef UART_ARB_LOCK_EN
    .req_lock        (req_lock),
`endif
    .CLK             (CLK),
    .reset_external_n(reset_external_n),
    .req             (req),
    .req_data        (req_data),
    .cfg_sel         (cfg_sel),
    .baud_tick       (baud_tick),
    .tx_busy         (tx_busy),
    .tx_start        (tx_start),
    .tx_data         (tx_data),
    .tx_owner        (tx_owner),
    .grant_ack       (grant_ack),
    .baud_sel        (baud_sel),
    .busy            (busy),
    .err_timeout     (err_timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!tx_start && k < 12);
    chk(tag, {31'd0, tx_start}, 1);
  endtask

  task automatic finish_frame(input int dly, input int len);
    step(dly);
    tx_busy = 1'b1;
    step(1);
    baud_tick = 1'b1;
    step(1);
    baud_tick = 1'b0;
    step(len);
    tx_busy = 1'b0;
    step(1);
    chk("gap_wait_busy", {31'd0, busy}, 1);
    baud_tick = 1'b1;
    step(1);
    baud_tick = 1'b0;
    chk("gap_done_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    reset_external_n = 1'b0;
    req       = '1;
    req_data  = 32'h43A5_2110;
    cfg_sel   = 3'd0;
    baud_tick = 1'b0;
    tx_busy   = 1'b0;

    step(2);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_grant", {28'd0, grant_ack}, 0);
    chk("rst_baud", {29'd0, baud_sel}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_owner", {30'd0, tx_owner}, 0);
    chk("rst_err", {31'd0, err_timeout}, 0);
    chk("rst_data", {24'd0, tx_data}, 0);
    reset_external_n = 1'b1;

    // round robin with all requesters busy
    for (int i = 0; i < 5; i++) begin
      wait_start("rr_start");
      chk("rr_owner", {30'd0, tx_owner}, i % 4);
      chk("rr_grant", {28'd0, grant_ack}, 1 << (i % 4));
      req[i % 4] = 1'b0;
      step(1);
      req = (i == 4) ? 4'h0 : 4'hF;
      finish_frame(1, 3);
    end

    // single requester, latency and data
    req = 4'b0100;
    step(1);
    chk("lat_t1_start", {31'd0, tx_start}, 0);
    step(1);
    chk("lat_t2_start", {31'd0, tx_start}, 1);
    chk("r2_data", {24'd0, tx_data}, 32'hA5);
    chk("r2_owner", {30'd0, tx_owner}, 2);
    chk("r2_grant", {28'd0, grant_ack}, 4'b0100);
    req = 4'b0000;
    step(1);
    chk("r2_start_pulse", {31'd0, tx_start}, 0);
    chk("r2_grant_pulse", {28'd0, grant_ack}, 0);
    chk("r2_data_hold", {24'd0, tx_data}, 32'hA5);
    finish_frame(1, 20);

    // baud select held until idle
    req = 4'b0010;
    wait_start("cfg_start");
    chk("cfg_owner", {30'd0, tx_owner}, 1);
    req = 4'b0000;
    step(1);
    tx_busy = 1'b1;
    step(2);
    cfg_sel = 3'd4;
    step(2);
    chk("cfg_hold_busy", {29'd0, baud_sel}, 0);
    tx_busy = 1'b0;
    step(1);
    chk("cfg_hold_gap", {29'd0, baud_sel}, 0);
    baud_tick = 1'b1;
    step(1);
    baud_tick = 1'b0;
    chk("cfg_hold_edge", {29'd0, baud_sel}, 0);
    step(1);
    chk("cfg_applied", {29'd0, baud_sel}, 4);
    req = 4'b1000;
    wait_start("cfg2_start");
    chk("cfg2_baud", {29'd0, baud_sel}, 4);
    chk("cfg2_owner", {30'd0, tx_owner}, 3);
    req = 4'b0000;
    finish_frame(1, 3);

    // start timeout, then next rr index
    req = 4'hF;
    wait_start("to_start");
    chk("to_owner", {30'd0, tx_owner}, 0);
    step(7);
    chk("to_err_early", {31'd0, err_timeout}, 0);
    chk("to_busy_early", {31'd0, busy}, 1);
    step(1);
    chk("to_err_pulse", {31'd0, err_timeout}, 1);
    chk("to_busy_idle", {31'd0, busy}, 0);
    step(1);
    chk("to_err_clear", {31'd0, err_timeout}, 0);
    wait_start("to_next_start");
    chk("to_next_owner", {30'd0, tx_owner}, 1);
    chk("to_next_grant", {28'd0, grant_ack}, 4'b0010);

    // asynchronous reset during WAIT_DONE
    req = 4'h0;
    step(1);
    tx_busy = 1'b1;
    step(3);
    chk("ar_busy_before", {31'd0, busy}, 1);
    #2 reset_external_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy}, 0);
    chk("ar_tx_start", {31'd0, tx_start}, 0);
    chk("ar_grant", {28'd0, grant_ack}, 0);
    chk("ar_baud", {29'd0, baud_sel}, 0);
    @(negedge CLK);
    reset_external_n = 1'b1;
    tx_busy = 1'b0;
    req = 4'hF;
    wait_start("ar_start");
    chk("ar_owner", {30'd0, tx_owner}, 0);
    chk("ar_first_grant", {28'd0, grant_ack}, 4'b0001);
    req = 4'h0;
    finish_frame(1, 3);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
